pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: bubble cycles inserted after halt detection before end_program.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  level; leaves IDLE and begins execution.
REQ-006 SHALL have port if_instr  in  32  instruction currently in IF.
REQ-007 SHALL have ports if_id_rs1, if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-008 SHALL have ports id_ex_mem_read (in, 1) and id_ex_rd (in, 5): load flag and destination of the instruction in EX.
REQ-009 SHALL have port ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 SHALL have ports pc_write, if_id_write, if_id_flush, id_ex_flush  out  1 each  pipeline-register enables/flushes.
REQ-011 SHALL have port end_program  out  1  program finished and pipeline drained.
REQ-012 SHALL have ports cycle_count and stall_count  out  CNT_W each  performance counters.
REQ-013 SHALL have port state  out  2  encoded FSM state: IDLE=0, RUN=1, DRAIN=2, DONE=3.

Function
REQ-014 FSM transitions: IDLE->RUN when start=1; RUN->DRAIN on a halt condition; DRAIN->DONE after DRAIN_CYCLES cycles in DRAIN; DONE holds until reset.
REQ-015 Halt condition: state=RUN, if_instr=32'h0, ex_branch_taken=0, no load-use stall that cycle.
REQ-016 Load-use stall: state=RUN, id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals if_id_rs1 or if_id_rs2.
REQ-017 In RUN with ex_branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; branch takes priority over load-use stall, and no stall is counted.
REQ-018 In RUN with load-use stall (no branch): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
REQ-019 In RUN otherwise: pc_write=1, if_id_write=1, both flushes 0.
REQ-020 In RUN on the halt cycle itself: pc_write=0, if_id_flush=1 (the zero word is not fetched past).
REQ-021 In DRAIN: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_flush=0; ex_branch_taken and the stall condition are ignored.
REQ-022 In IDLE and DONE: pc_write=0, if_id_write=0, both flushes 0.
REQ-023 Control outputs are combinational from state and inputs; end_program is registered and equals 1 exactly when state=DONE.
REQ-024 Drain counter: loads 0 on RUN->DRAIN, increments each DRAIN cycle; the transition occurs on the edge at which the counter equals DRAIN_CYCLES-1, giving exactly DRAIN_CYCLES DRAIN cycles; DRAIN_CYCLES=0 is illegal.
REQ-025 cycle_count increments by 1 on every cycle in RUN or DRAIN and saturates at all-ones.
REQ-026 stall_count increments by 1 on every load-use stall cycle (REQ-018) and saturates at all-ones.
REQ-027 Both counters hold their value in DONE and IDLE.

Reset
REQ-028 reset=0 asynchronously forces state=IDLE, drain counter=0, cycle_count=0, stall_count=0, end_program=0.
REQ-029 Reset asserted mid-RUN or mid-DRAIN aborts the operation; no counter value survives.
REQ-030 After reset release, the FSM stays in IDLE until start=1 is sampled on a rising edge.

Structure
REQ-031 FSM state encodings and the halt opcode constant (32'h0) SHALL live in the shared CPU package alongside the opcode constants.
REQ-032 One sub-module SHALL be instantiated: sat_counter (parameterised width, inc, clear, saturating); it is used twice.

Verification
REQ-033 Reset, start=1, if_instr=32'h00400293 for 10 cycles -> state=RUN, pc_write=1, cycle_count=10, stall_count=0.
REQ-034 id_ex_mem_read=1, id_ex_rd=5, if_id_rs1=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_count increments to 1; with id_ex_rd=0 -> no stall.
REQ-035 Load-use condition and ex_branch_taken=1 in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_count unchanged.
REQ-036 if_instr=0 in RUN -> DRAIN for exactly 4 cycles, end_program=1 on the 5th edge, state=3, cycle_count frozen; if_instr=0 with ex_branch_taken=1 -> stays in RUN.
REQ-037 Reset pulsed during DRAIN -> state=0, end_program=0, counters=0 immediately, without waiting for a clock edge.
REQ-038 CNT_W=4, run 20 cycles -> cycle_count saturates at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU package: opcode constants, pipeline-control FSM encodings and payload types.
package pipeline_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // Major RV32I opcodes decoded elsewhere in the core
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    // All-zero instruction word terminates the program
    localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0000;

    // Pipeline-control FSM encodings (externally visible on the state port)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Pipeline-register enables and flushes driven by the hazard unit
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } hazard_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc, sticking at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: run/drain/done sequencing, load-use and branch hazard
// control, and cycle/stall performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4,   // must be >= 1
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      if_instr,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             end_program,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam int unsigned     DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_drain_cnt;
    logic          r_end_program;

    logic [1:0]    w_next_state;
    logic [DW-1:0] w_drain_next;
    hazard_ctrl_t  w_ctrl;
    logic          w_load_use;
    logic          w_halt;
    logic          w_stall_inc;
    logic          w_cycle_inc;

    // Hazard detection; branch redirect outranks both stall and halt
    assign w_load_use  = (r_state == ST_RUN) && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                         ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign w_halt      = (r_state == ST_RUN) && (if_instr == HALT_INSTR) &&
                         !ex_branch_taken && !w_load_use;
    assign w_stall_inc = w_load_use && !ex_branch_taken;
    assign w_cycle_inc = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    // State, drain counter and registered end flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_drain_cnt   <= '0;
            r_end_program <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_drain_cnt   <= w_drain_next;
            r_end_program <= (w_next_state == ST_DONE);
        end
    end

    // Next-state and combinational pipeline-register control
    always_comb begin
        w_next_state = r_state;
        w_drain_next = r_drain_cnt;
        w_ctrl       = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0};
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
                end else if (w_load_use) begin
                    w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1};
                end else if (w_halt) begin
                    // Freeze the PC on the zero word and start inserting bubbles
                    w_ctrl       = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
                    w_next_state = ST_DRAIN;
                    w_drain_next = '0;
                end else begin
                    w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
                end
            end
            ST_DRAIN: begin
                w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next_state = ST_DONE;
                    w_drain_next = '0;
                end else begin
                    w_drain_next = r_drain_cnt + DW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (w_cycle_inc),
        .o_count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (w_stall_inc),
        .o_count (stall_count)
    );

    assign pc_write    = w_ctrl.pc_write;
    assign if_id_write = w_ctrl.if_id_write;
    assign if_id_flush = w_ctrl.if_id_flush;
    assign id_ex_flush = w_ctrl.id_ex_flush;
    assign end_program = r_end_program;
    assign state       = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a cycle-level reference model feeds an
// expectation queue that a separate monitor drains and compares.
module tb_pipeline_ctrl;

    localparam int unsigned DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] if_instr;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        id_ex_mem_read, ex_branch_taken;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, end_program;
    logic [31:0] cycle_count, stall_count;
    logic [1:0]  state;

    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, end_program4;
    logic [3:0]  cycle_count4, stall_count4;
    logic [1:0]  state4;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .if_instr(if_instr),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .end_program(end_program), .cycle_count(cycle_count),
        .stall_count(stall_count), .state(state)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .if_instr(if_instr),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write4), .if_id_write(if_id_write4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .end_program(end_program4), .cycle_count(cycle_count4),
        .stall_count(stall_count4), .state(state4)
    );

    typedef struct {
        logic [1:0]  st;
        logic        endp;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [3:0]  cyc4;
        logic [3:0]  stl4;
        logic [3:0]  ctrl;   // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: phase name as number, bubbles still to insert, plain integer counts
    int m_state, m_left, m_cycles, m_stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic model_reset();
        m_state = 0; m_left = 0; m_cycles = 0; m_stalls = 0;
    endtask

    // Drive one cycle of inputs, queue the expected response, advance the model over the edge
    task automatic drive(input logic rst, input logic st, input logic [31:0] instr,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br);
        exp_t e;
        bit   stall, halt;
        @(negedge clk);
        reset = rst; start = st; if_instr = instr; if_id_rs1 = rs1; if_id_rs2 = rs2;
        id_ex_rd = rd; id_ex_mem_read = mr; ex_branch_taken = br;
        if (!rst) model_reset();
        stall = (m_state == 1) && mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
        halt  = (m_state == 1) && (instr == 0) && !br && !stall;
        e.st   = 2'(m_state);
        e.endp = (m_state == 3);
        e.cyc  = 32'(m_cycles);
        e.stl  = 32'(m_stalls);
        e.cyc4 = sat4(m_cycles);
        e.stl4 = sat4(m_stalls);
        if (m_state == 1) begin
            if (br)         e.ctrl = 4'b1111;
            else if (stall) e.ctrl = 4'b0001;
            else if (halt)  e.ctrl = 4'b0110;
            else            e.ctrl = 4'b1100;
        end else if (m_state == 2) begin
            e.ctrl = 4'b0110;
        end else begin
            e.ctrl = 4'b0000;
        end
        q.push_back(e);
        if (rst) begin
            if (m_state == 1 || m_state == 2) m_cycles++;
            if (stall && !br) m_stalls++;
            case (m_state)
                0: if (st) m_state = 1;
                1: if (halt) begin m_state = 2; m_left = DRAIN; end
                2: begin m_left--; if (m_left == 0) m_state = 3; end
                default: ;
            endcase
        end
    endtask

    task automatic run_plain(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 32'h0040_0293, 5'd1, 5'd2, 5'd3, 0, 0);
    endtask

    task automatic drive_random(input int n, input bit allow_halt);
        logic [31:0] instr;
        logic        br;
        for (int i = 0; i < n; i++) begin
            instr = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
            br    = ($urandom_range(0, 4) == 0);
            if (!allow_halt && instr == 0) br = 1'b1;
            drive(1, 1'($urandom_range(0, 1)), instr, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), br);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the DUTs in the low phase
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", 64'(state), 64'(e.st));
                chk("end_program", 64'(end_program), 64'(e.endp));
                chk("cycle_count", 64'(cycle_count), 64'(e.cyc));
                chk("stall_count", 64'(stall_count), 64'(e.stl));
                chk("cycle_count_w4", 64'(cycle_count4), 64'(e.cyc4));
                chk("stall_count_w4", 64'(stall_count4), 64'(e.stl4));
                chk("ctrl", 64'({pc_write, if_id_write, if_id_flush, id_ex_flush}), 64'(e.ctrl));
                chk("ctrl_w4", 64'({pc_write4, if_id_write4, if_id_flush4, id_ex_flush4}), 64'(e.ctrl));
                chk("state_w4", 64'(state4), 64'(e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; start = 0; if_instr = 32'h0; if_id_rs1 = 0; if_id_rs2 = 0;
        id_ex_rd = 0; id_ex_mem_read = 0; ex_branch_taken = 0;
        model_reset();
        #3;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_cycle_count", 64'(cycle_count), 64'd0);
        chk("reset_end_program", 64'(end_program), 64'd0);
        drive(0, 1, 32'h0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);

        // Idle holds without start, then 10 plain RUN cycles
        drive(1, 0, 32'h0040_0293, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h0040_0293, 0, 0, 0, 0, 0);
        run_plain(10);
        after_edge();
        chk("run10_state", 64'(state), 64'd1);
        chk("run10_cycle_count", 64'(cycle_count), 64'd10);
        chk("run10_stall_count", 64'(stall_count), 64'd0);

        // Load-use stall, rd=0 non-stall, then branch overriding a load-use
        drive(1, 1, 32'h0040_0293, 5'd5, 5'd0, 5'd5, 1, 0);
        after_edge();
        chk("loaduse_stall_count", 64'(stall_count), 64'd1);
        drive(1, 1, 32'h0040_0293, 5'd0, 5'd0, 5'd0, 1, 0);
        drive(1, 1, 32'h0040_0293, 5'd7, 5'd5, 5'd5, 1, 1);
        after_edge();
        chk("branch_over_stall_count", 64'(stall_count), 64'd1);

        // Randomized RUN traffic; w4 counters saturate along the way
        drive_random(60, 0);

        // Zero word with branch stays in RUN; plain zero word halts and drains
        drive(1, 1, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1);
        after_edge();
        chk("zero_with_branch_state", 64'(state), 64'd1);
        drive(1, 1, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0);
        drive_random(DRAIN + 4, 1);
        chk("done_end_program", 64'(end_program), 64'd1);
        chk("done_cycle_w4", 64'(cycle_count4), 64'd15);

        // Abort mid-DRAIN with an asynchronous reset between clock edges
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h0040_0293, 0, 0, 0, 0, 0);
        drive_random(5, 0);
        drive(1, 1, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0);
        drive_random(2, 1);
        @(posedge clk);
        #2;
        reset = 0;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_end_program", 64'(end_program), 64'd0);
        chk("async_rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("async_rst_stall_count", 64'(stall_count), 64'd0);
        model_reset();
        drive(0, 1, 32'h0, 0, 0, 0, 0, 0);

        // Recovery: full random program through to DONE
        drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h0040_0293, 0, 0, 0, 0, 0);
        drive_random(40, 0);
        drive(1, 1, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0);
        drive_random(DRAIN + 3, 1);

        @(negedge clk);
        #4;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
